// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - operand id encoding and decode helpers for the register file
package reg_file_sb_pkg;

    localparam int REG_FILE_SIZE = 20;
    localparam int NUM_REGS      = REG_FILE_SIZE;
    localparam int FAKE_W        = 64;
    localparam int RSP_IDX       = 4;

    typedef logic [7:0] reg_id_t;

    // id[7]=0 selects a fake source; codes above RV8 are undefined
    localparam reg_id_t RNIL = 8'h00;
    localparam reg_id_t RIP  = 8'h01;
    localparam reg_id_t RIMM = 8'h02;
    localparam reg_id_t RV0  = 8'h03;
    localparam reg_id_t RV8  = 8'h04;

    localparam reg_id_t RAX = 8'h80;
    localparam reg_id_t RCX = 8'h81;
    localparam reg_id_t RDX = 8'h82;
    localparam reg_id_t RBX = 8'h83;
    localparam reg_id_t RSP = 8'h84;
    localparam reg_id_t RBP = 8'h85;
    localparam reg_id_t RSI = 8'h86;
    localparam reg_id_t RDI = 8'h87;
    localparam reg_id_t RHC = 8'h93;

    function automatic logic is_real(reg_id_t id, int unsigned nregs = NUM_REGS);
        return id[7] && (32'(id[6:0]) < nregs);
    endfunction

    function automatic logic is_fake(reg_id_t id);
        return !id[7] && (id <= RV8);
    endfunction

    function automatic logic [FAKE_W-1:0] fake_value(reg_id_t id, logic [FAKE_W-1:0] imm,
                                                     logic [FAKE_W-1:0] pc);
        logic [FAKE_W-1:0] v;
        case (id)
            RV8:     v = FAKE_W'(8);
            RIMM:    v = imm;
            RIP:     v = pc;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode/writeback side bundle of the register file
interface reg_file_sb_if #(
    parameter int NUM_RD = 3,
    parameter int NUM_WR = 2,
    parameter int DATA_W = 64
);
    logic [NUM_RD-1:0][7:0]        rd_id;
    logic [DATA_W-1:0]             rd_imm;
    logic [DATA_W-1:0]             rd_pc;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic                          claim_valid;
    logic [7:0]                    claim_id;
    logic                          claim_ok;
    logic [NUM_WR-1:0]             wr_valid;
    logic [NUM_WR-1:0][7:0]        wr_id;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          flush;
    logic                          err;

    modport master (
        output rd_id, rd_imm, rd_pc, claim_valid, claim_id, wr_valid, wr_id, wr_data, flush,
        input  rd_data, rd_busy, claim_ok, err
    );

    modport slave (
        input  rd_id, rd_imm, rd_pc, claim_valid, claim_id, wr_valid, wr_id, wr_data, flush,
        output rd_data, rd_busy, claim_ok, err
    );
endinterface

// File: rtl/reg_file_sb_src_mux.sv
// rtl/reg_file_sb_src_mux.sv - one read port: fake decode, write bypass, stored value
module reg_src_mux
    import reg_file_sb_pkg::*;
#(
    parameter int NUM_WR   = 2,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = REG_FILE_SIZE
) (
    input  reg_id_t                       rd_id_i,
    input  logic [DATA_W-1:0]             imm_i,
    input  logic [DATA_W-1:0]             pc_i,
    input  logic [NUM_WR-1:0]             wr_valid_i,
    input  logic [NUM_WR-1:0][7:0]        wr_id_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0]             regs_i [NUM_REGS],
    input  logic [NUM_REGS-1:0]           busy_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          busy_o,
    output logic                          undef_o
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [IDX_W-1:0]  idx;
    logic [FAKE_W-1:0] fake_v;

    assign idx = rd_id_i[IDX_W-1:0];

    always_comb begin
        data_o  = '0;
        busy_o  = 1'b0;
        undef_o = 1'b0;
        fake_v  = fake_value(rd_id_i, FAKE_W'(imm_i), FAKE_W'(pc_i));
        if (is_real(rd_id_i, NUM_REGS)) begin
            data_o = regs_i[idx];
            busy_o = busy_i[idx];
            // ascending scan so the highest write port ends up winning
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid_i[k] && (wr_id_i[k] == rd_id_i)) begin
                    data_o = wr_data_i[k];
                    busy_o = 1'b0;
                end
            end
        end else if (is_fake(rd_id_i)) begin
            data_o = fake_v[DATA_W-1:0];
        end else begin
            undef_o = 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-ported register file with busy scoreboard
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int              NUM_RD   = 3,
    parameter int              NUM_WR   = 2,
    parameter int              DATA_W   = 64,
    parameter int              NUM_REGS = REG_FILE_SIZE,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    reg_file_sb_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef logic [DATA_W-1:0] reg_data_t;

    reg_data_t             regs_q [NUM_REGS];
    reg_data_t             regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  err_q, err_d;

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_RD-1:0]             rd_undef;

    logic [NUM_WR-1:0] wr_real;
    logic              wr_bad;
    logic              wr_collide;
    logic              claim_real;
    logic              claim_nil;
    logic              claim_hit;
    logic              claim_bad;
    logic              claim_ok;
    logic [IDX_W-1:0]  claim_idx;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        reg_src_mux #(
            .NUM_WR   (NUM_WR),
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS)
        ) u_mux (
            .rd_id_i    (bus.rd_id[g]),
            .imm_i      (bus.rd_imm),
            .pc_i       (bus.rd_pc),
            .wr_valid_i (bus.wr_valid),
            .wr_id_i    (bus.wr_id),
            .wr_data_i  (bus.wr_data),
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .data_o     (rd_data[g]),
            .busy_o     (rd_busy[g]),
            .undef_o    (rd_undef[g])
        );
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.claim_ok = claim_ok;
    assign bus.err      = err_q;

    always_comb begin
        wr_bad     = 1'b0;
        wr_collide = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_real[k] = bus.wr_valid[k] && is_real(bus.wr_id[k], NUM_REGS);
            if (bus.wr_valid[k] && !wr_real[k]) wr_bad = 1'b1;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_real[j] && wr_real[k] && (bus.wr_id[j] == bus.wr_id[k])) wr_collide = 1'b1;
            end
        end
    end

    always_comb begin
        claim_idx  = bus.claim_id[IDX_W-1:0];
        claim_real = is_real(bus.claim_id, NUM_REGS);
        claim_nil  = (bus.claim_id == RNIL);
        claim_hit  = 1'b0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_real[k] && (bus.wr_id[k] == bus.claim_id)) claim_hit = 1'b1;
        end
        claim_ok  = bus.claim_valid &&
                    (claim_nil || (claim_real && (!busy_q[claim_idx] || claim_hit)));
        claim_bad = bus.claim_valid && !claim_real && !claim_nil;
    end

    // Priority: flush, then write clears, then a claim re-sets its bit
    always_comb begin
        regs_d = regs_q;
        busy_d = bus.flush ? '0 : busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_real[k]) begin
                regs_d[bus.wr_id[k][IDX_W-1:0]] = bus.wr_data[k];
                busy_d[bus.wr_id[k][IDX_W-1:0]] = 1'b0;
            end
        end
        if (claim_ok && claim_real) busy_d[claim_idx] = 1'b1;
        err_d = (|rd_undef) || wr_bad || wr_collide || claim_bad;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    reg_file_sb_if #(.NUM_RD(3), .NUM_WR(2), .DATA_W(64)) bus ();

    reg_file_sb #(
        .NUM_RD   (3),
        .NUM_WR   (2),
        .DATA_W   (64),
        .NUM_REGS (20),
        .RSP_INIT (64'h7000)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.claim_valid = 1'b0;
        bus.claim_id    = RNIL;
        bus.wr_valid    = '0;
        bus.wr_id       = '0;
        bus.wr_data     = '0;
        bus.flush       = 1'b0;
        bus.rd_id[0]    = RAX;
        bus.rd_id[1]    = RAX;
        bus.rd_id[2]    = RAX;
    endtask

    task automatic test_reset();
        idle();
        bus.rd_imm = '0;
        bus.rd_pc  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.rd_id[0] = RSP;
        bus.rd_id[1] = RAX;
        bus.rd_id[2] = RBX;
        #1;
        n_cmp++; if (bus.rd_data[0] !== 64'h7000) begin n_bad++; $display("FAIL reset_rsp got %h exp %h", bus.rd_data[0], 64'h7000); end
        n_cmp++; if (bus.rd_data[1] !== 64'h0) begin n_bad++; $display("FAIL reset_rax got %h exp 0", bus.rd_data[1]); end
        n_cmp++; if (bus.rd_busy !== 3'b000) begin n_bad++; $display("FAIL reset_busy got %b exp 000", bus.rd_busy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", bus.err); end
    endtask

    task automatic test_claim_write();
        idle();
        bus.claim_valid = 1'b1;
        bus.claim_id    = RBX;
        #1;
        n_cmp++; if (bus.claim_ok !== 1'b1) begin n_bad++; $display("FAIL claim_rbx_ok got %b exp 1", bus.claim_ok); end
        tick();
        bus.claim_valid = 1'b0;
        bus.rd_id[0]    = RBX;
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rbx_busy got %b exp 1", bus.rd_busy[0]); end
        bus.claim_valid = 1'b1;
        #1;
        n_cmp++; if (bus.claim_ok !== 1'b0) begin n_bad++; $display("FAIL reclaim_rbx got %b exp 0", bus.claim_ok); end
        tick();
        bus.claim_valid = 1'b0;
        #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL busy_reject_err got %b exp 0", bus.err); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rbx_still_busy got %b exp 1", bus.rd_busy[0]); end
        bus.wr_valid   = 2'b01;
        bus.wr_id[0]   = RBX;
        bus.wr_data[0] = 64'hDEAD;
        tick();
        bus.wr_valid = '0;
        #1;
        n_cmp++; if (bus.rd_data[0] !== 64'hDEAD) begin n_bad++; $display("FAIL rbx_write got %h exp %h", bus.rd_data[0], 64'hDEAD); end
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL rbx_cleared got %b exp 0", bus.rd_busy[0]); end
    endtask

    task automatic test_bypass();
        idle();
        bus.wr_valid   = 2'b10;
        bus.wr_id[1]   = RCX;
        bus.wr_data[1] = 64'd5;
        bus.rd_id[1]   = RCX;
        #1;
        n_cmp++; if (bus.rd_data[1] !== 64'd5) begin n_bad++; $display("FAIL bypass_rcx got %h exp 5", bus.rd_data[1]); end
        n_cmp++; if (bus.rd_busy[1] !== 1'b0) begin n_bad++; $display("FAIL bypass_busy got %b exp 0", bus.rd_busy[1]); end
        tick();
        bus.wr_valid   = 2'b11;
        bus.wr_id[0]   = RCX;
        bus.wr_data[0] = 64'd1;
        bus.wr_id[1]   = RCX;
        bus.wr_data[1] = 64'd2;
        #1;
        n_cmp++; if (bus.rd_data[1] !== 64'd2) begin n_bad++; $display("FAIL bypass_high_port got %h exp 2", bus.rd_data[1]); end
        tick();
        bus.wr_valid = '0;
        #1;
        n_cmp++; if (bus.rd_data[1] !== 64'd2) begin n_bad++; $display("FAIL collide_value got %h exp 2", bus.rd_data[1]); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL collide_err got %b exp 1", bus.err); end
        tick();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL collide_err_drop got %b exp 0", bus.err); end
    endtask

    task automatic test_fake();
        idle();
        bus.rd_imm   = 64'h42;
        bus.rd_pc    = 64'h400000;
        bus.rd_id[0] = RNIL;
        bus.rd_id[1] = RV8;
        bus.rd_id[2] = RIMM;
        #1;
        n_cmp++; if (bus.rd_data[0] !== 64'h0) begin n_bad++; $display("FAIL fake_rnil got %h exp 0", bus.rd_data[0]); end
        n_cmp++; if (bus.rd_data[1] !== 64'h8) begin n_bad++; $display("FAIL fake_rv8 got %h exp 8", bus.rd_data[1]); end
        n_cmp++; if (bus.rd_data[2] !== 64'h42) begin n_bad++; $display("FAIL fake_rimm got %h exp 42", bus.rd_data[2]); end
        n_cmp++; if (bus.rd_busy !== 3'b000) begin n_bad++; $display("FAIL fake_busy got %b exp 000", bus.rd_busy); end
        bus.rd_id[0] = RIP;
        bus.rd_id[1] = RV0;
        #1;
        n_cmp++; if (bus.rd_data[0] !== 64'h400000) begin n_bad++; $display("FAIL fake_rip got %h exp 400000", bus.rd_data[0]); end
        n_cmp++; if (bus.rd_data[1] !== 64'h0) begin n_bad++; $display("FAIL fake_rv0 got %h exp 0", bus.rd_data[1]); end
        tick();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL fake_err got %b exp 0", bus.err); end
    endtask

    task automatic test_claim_override_flush();
        idle();
        bus.claim_valid = 1'b1;
        bus.claim_id    = RDX;
        tick();
        bus.wr_valid    = 2'b01;
        bus.wr_id[0]    = RDX;
        bus.wr_data[0]  = 64'd9;
        #1;
        n_cmp++; if (bus.claim_ok !== 1'b1) begin n_bad++; $display("FAIL claim_with_write got %b exp 1", bus.claim_ok); end
        tick();
        idle();
        bus.rd_id[0] = RDX;
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL claim_overrides_clear got %b exp 1", bus.rd_busy[0]); end
        n_cmp++; if (bus.rd_data[0] !== 64'd9) begin n_bad++; $display("FAIL rdx_value got %h exp 9", bus.rd_data[0]); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b0) begin n_bad++; $display("FAIL flush_clears got %b exp 0", bus.rd_busy[0]); end
        bus.claim_valid = 1'b1;
        bus.claim_id    = RDX;
        tick();
        bus.claim_id = RAX;
        bus.flush    = 1'b1;
        tick();
        idle();
        bus.rd_id[0] = RDX;
        bus.rd_id[1] = RAX;
        #1;
        n_cmp++; if (bus.rd_busy[1:0] !== 2'b10) begin n_bad++; $display("FAIL flush_with_claim got %b exp 10", bus.rd_busy[1:0]); end
    endtask

    task automatic test_bad_ids();
        idle();
        bus.wr_valid   = 2'b01;
        bus.wr_id[0]   = 8'h95;
        bus.wr_data[0] = 64'hFFFF;
        bus.rd_id[2]   = 8'h05;
        #1;
        n_cmp++; if (bus.rd_data[2] !== 64'h0) begin n_bad++; $display("FAIL undef_read_data got %h exp 0", bus.rd_data[2]); end
        n_cmp++; if (bus.rd_busy[2] !== 1'b0) begin n_bad++; $display("FAIL undef_read_busy got %b exp 0", bus.rd_busy[2]); end
        tick();
        idle();
        bus.rd_id[0] = RBP;
        #1;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL undef_err got %b exp 1", bus.err); end
        n_cmp++; if (bus.rd_data[0] !== 64'h0) begin n_bad++; $display("FAIL undef_write_dropped got %h exp 0", bus.rd_data[0]); end
        tick();
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL undef_err_once got %b exp 0", bus.err); end
        bus.claim_valid = 1'b1;
        bus.claim_id    = RIMM;
        #1;
        n_cmp++; if (bus.claim_ok !== 1'b0) begin n_bad++; $display("FAIL claim_fake_ok got %b exp 0", bus.claim_ok); end
        bus.claim_id = RNIL;
        #1;
        n_cmp++; if (bus.claim_ok !== 1'b1) begin n_bad++; $display("FAIL claim_rnil_ok got %b exp 1", bus.claim_ok); end
        tick();
        bus.claim_valid = 1'b0;
        #1;
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL claim_rnil_err got %b exp 0", bus.err); end
    endtask

    task automatic test_reset_pending();
        idle();
        bus.claim_valid = 1'b1;
        bus.claim_id    = RSI;
        tick();
        bus.rd_id[0] = RSI;
        #1;
        n_cmp++; if (bus.rd_busy[0] !== 1'b1) begin n_bad++; $display("FAIL rsi_busy got %b exp 1", bus.rd_busy[0]); end
        reset           = 1'b1;
        bus.claim_id    = RBP;
        bus.wr_valid    = 2'b01;
        bus.wr_id[0]    = RCX;
        bus.wr_data[0]  = 64'h77;
        tick();
        reset = 1'b0;
        idle();
        bus.rd_id[0] = RSI;
        bus.rd_id[1] = RBP;
        bus.rd_id[2] = RCX;
        #1;
        n_cmp++; if (bus.rd_busy !== 3'b000) begin n_bad++; $display("FAIL reset_pending_busy got %b exp 000", bus.rd_busy); end
        n_cmp++; if (bus.rd_data[2] !== 64'h0) begin n_bad++; $display("FAIL reset_rcx got %h exp 0", bus.rd_data[2]); end
        bus.rd_id[0] = RSP;
        bus.rd_id[1] = RDX;
        #1;
        n_cmp++; if (bus.rd_data[0] !== 64'h7000) begin n_bad++; $display("FAIL reset_rsp_again got %h exp 7000", bus.rd_data[0]); end
        n_cmp++; if (bus.rd_data[1] !== 64'h0) begin n_bad++; $display("FAIL reset_rdx got %h exp 0", bus.rd_data[1]); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_pending_err got %b exp 0", bus.err); end
    endtask

    initial begin
        test_reset();
        test_claim_write();
        test_bypass();
        test_fake();
        test_claim_override_flush();
        test_bad_ids();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
